// File: rtl/cpu16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cpu16_pkg                                                   |
// | Brief  : Shared opcodes, IR field helpers and hazard FSM encoding    |
// |          for the 16-bit pipelined CPU.                               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package cpu16_pkg;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  // Hazard controller state encoding
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } hz_state_e;

  // IR field slices: op[15:12], rs[11:10], rt[9:8], rd[7:6]
  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [1:0] ir_rs(input logic [15:0] ir);
    return ir[11:10];
  endfunction

  function automatic logic [1:0] ir_rt(input logic [15:0] ir);
    return ir[9:8];
  endfunction

  function automatic logic [1:0] ir_rd(input logic [15:0] ir);
    return ir[7:6];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hazard_decode                                               |
// | Brief  : Combinational register-usage decode of the IF/ID            |
// |          instruction: sources, destination and branch flag.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module hazard_decode
  import cpu16_pkg::*;
(
  input  logic [15:0] ifid_ir,
  output logic [1:0]  src1,
  output logic [1:0]  src2,
  output logic        use1,
  output logic        use2,
  output logic [1:0]  dst,
  output logic        has_dst,
  output logic        is_br
);

  // Immediate / offset bits never name a register
  logic unused_low;
  assign unused_low = ^ifid_ir[5:0];

  // Classify the opcode into which register fields are read and written
  always_comb begin
    src1    = ir_rs(ifid_ir);
    src2    = ir_rt(ifid_ir);
    use1    = 1'b0;
    use2    = 1'b0;
    dst     = 2'd0;
    has_dst = 1'b0;
    is_br   = 1'b0;
    case (ir_op(ifid_ir))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        use1    = 1'b1;
        use2    = 1'b1;
        dst     = ir_rd(ifid_ir);
        has_dst = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use1    = 1'b1;
        dst     = ir_rt(ifid_ir);
        has_dst = 1'b1;
      end
      OP_SW: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use1  = 1'b1;
        use2  = 1'b1;
        is_br = 1'b1;
      end
      default: begin
        use1 = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hazard_ctrl                                                 |
// | Brief  : RAW scoreboard, branch-resolve hold and IF/ID flush control |
// |          with saturating stall/flush performance counters.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module hazard_ctrl
  import cpu16_pkg::*;
#(
  parameter int WB_LAT = 2,
  parameter int BR_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      ifid_ir,
  input  logic             br_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int PW = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);
  localparam int BW = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;
  localparam logic [PW-1:0]    PEND_LOAD = PW'(WB_LAT);
  localparam logic [BW-1:0]    BCNT_INIT = BW'(BR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0] src1, src2, dst;
  logic       use1, use2, has_dst, is_br;

  hazard_decode u_decode (
    .ifid_ir (ifid_ir),
    .src1    (src1),
    .src2    (src2),
    .use1    (use1),
    .use2    (use2),
    .dst     (dst),
    .has_dst (has_dst),
    .is_br   (is_br)
  );

  hz_state_e            state_q, state_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 flush_q, flush_d;
  logic [3:1][PW-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [3:0]           busy;
  logic                 raw;

  // A counter at 1 writes back on the same edge a reader transfers, so only >1 blocks
  always_comb begin
    busy = 4'b0000;
    for (int r = 1; r < 4; r++) begin
      busy[r] = (pend_q[r] > PW'(1));
    end
    raw = (use1 && busy[src1]) || (use2 && busy[src2]);
  end

  // Issue FSM: RAW stall, branch hold, and the bubble for the flush cycle
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    flush_d = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_q) begin
          // IF/ID holds a wrong-path instruction and is being zeroed this edge
          bubble = 1'b1;
        end else if (raw) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end else if (is_br) begin
          state_d = BR_WAIT;
          bcnt_d  = BCNT_INIT;
        end
      end
      BR_WAIT: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (bcnt_q == '0) begin
          state_d = RUN;
          flush_d = br_taken;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    issue = ~bubble;
  end

  // Scoreboard: counters drain every edge; an issuing writer reloads its slot
  always_comb begin
    for (int r = 1; r < 4; r++) begin
      pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - PW'(1) : '0;
      if (issue && has_dst && (dst == 2'(r))) begin
        pend_d[r] = PEND_LOAD;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_d && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers share the pipeline's falling edge
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      bcnt_q      <= '0;
      flush_q     <= 1'b0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      flush_q     <= flush_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush     = flush_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_hazard_ctrl                                              |
// | Brief  : Self-checking bench for hazard_ctrl with a cycle-time       |
// |          reference model and random instruction streams.             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int WB_LAT = 2;
  localparam int BR_LAT = 1;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [15:0]      ifid_ir = 16'h0000;
  logic             br_taken = 1'b0;
  logic             stall, bubble, flush, issue;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.WB_LAT(WB_LAT), .BR_LAT(BR_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ifid_ir   (ifid_ir),
    .br_taken  (br_taken),
    .stall     (stall),
    .bubble    (bubble),
    .flush     (flush),
    .issue     (issue),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time-stamped view of the pipeline
  int          t = 0;
  int          ready [4] = '{0, 0, 0, 0};  // first cycle a register may be read
  int          br_t = -1;                  // cycle the last branch issued
  int          flush_at = -1;              // cycle in which flush must be high
  int          m_scnt = 0, m_fcnt = 0;
  logic [15:0] ifid_m = 16'h0000;          // what IF/ID would hold next cycle

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  function automatic void decode(input logic [15:0] ir, output bit u1, output int s1,
                                 output bit u2, output int s2, output int d, output bit br);
    int op;
    op = int'(ir[15:12]);
    s1 = int'(ir[11:10]);
    s2 = int'(ir[9:8]);
    u1 = 0; u2 = 0; d = 0; br = 0;
    if (op inside {0, 1, 2, 3, 7}) begin u1 = 1; u2 = 1; d = int'(ir[7:6]); end
    else if (op inside {4, 5})     begin u1 = 1; d = int'(ir[9:8]); end
    else if (op == 6)              begin u1 = 1; u2 = 1; end
    else if (op inside {8, 9})     begin u1 = 1; u2 = 1; br = 1; end
  endfunction

  function automatic logic [15:0] rand_ir();
    return 16'($urandom_range(0, 65535));
  endfunction

  // One clock cycle: drive, compare against the model, advance the model
  task automatic step(input logic [15:0] ir, input logic bt, input logic rs);
    bit u1, u2, br, in_br, fl, raw;
    int s1, s2, d;
    bit m_stall, m_bubble;
    @(posedge clk);
    ifid_ir  = ir;
    br_taken = bt;
    reset    = rs;
    #1;
    decode(ir, u1, s1, u2, s2, d, br);
    in_br    = (br_t >= 0) && (t > br_t) && (t <= br_t + BR_LAT);
    fl       = (t == flush_at);
    raw      = (u1 && s1 != 0 && t < ready[s1]) || (u2 && s2 != 0 && t < ready[s2]);
    m_stall  = in_br || (!fl && raw);
    m_bubble = in_br || fl || raw;
    if (!rs) begin
      check1("stall",     32'(stall),     32'(m_stall));
      check1("bubble",    32'(bubble),    32'(m_bubble));
      check1("issue",     32'(issue),     32'(!m_bubble));
      check1("flush",     32'(flush),     32'(fl));
      check1("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      check1("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    end
    if (rs) begin
      for (int r = 0; r < 4; r++) ready[r] = 0;
      br_t = -1; flush_at = -1; m_scnt = 0; m_fcnt = 0;
      ifid_m = rand_ir();
    end else begin
      if (m_stall && m_scnt < CMAX) m_scnt++;
      if (!m_bubble && d != 0) ready[d] = t + WB_LAT;
      if (!m_bubble && br) br_t = t;
      if (in_br && t == br_t + BR_LAT && bt) begin
        flush_at = t + 1;
        if (m_fcnt < CMAX) m_fcnt++;
      end
      if (fl)           ifid_m = 16'h0000;
      else if (m_stall) ifid_m = ir;
      else              ifid_m = rand_ir();
    end
    t++;
  endtask

  initial begin
    // Reset for two edges, then idle state
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b0);
    check1("rst_stall", 32'(stall), 32'd0);
    check1("rst_bubble", 32'(bubble), 32'd0);
    check1("rst_flush", 32'(flush), 32'd0);
    check1("rst_issue", 32'(issue), 32'd1);
    check1("rst_scnt", 32'(stall_cnt), 32'd0);
    check1("rst_fcnt", 32'(flush_cnt), 32'd0);

    // addi $1,$0,15 ; and $3,$1,$2 -> one stall cycle
    step(16'h410F, 1'b0, 1'b0);
    step(16'h26C0, 1'b0, 1'b0);
    check1("raw_stall", 32'(stall), 32'd1);
    step(16'h26C0, 1'b0, 1'b0);
    check1("raw_issue", 32'(issue), 32'd1);
    check1("raw_scnt", 32'(stall_cnt), 32'd1);

    // addi $1 ; add $3,$0,$2 -> no stall; addi $1 ; sw $1 -> stall
    step(16'h410F, 1'b0, 1'b0);
    step(16'h02C0, 1'b0, 1'b0);
    check1("indep_issue", 32'(issue), 32'd1);
    step(16'h410F, 1'b0, 1'b0);
    step(16'h6900, 1'b0, 1'b0);
    check1("sw_stall", 32'(stall), 32'd1);
    step(16'h6900, 1'b0, 1'b0);
    check1("sw_issue", 32'(issue), 32'd1);

    // beq taken -> one BR_WAIT cycle, then a one-cycle flush
    step(16'h8000, 1'b0, 1'b0);
    check1("beq_issue", 32'(issue), 32'd1);
    step(16'h02C0, 1'b1, 1'b0);
    check1("brw_bubble", 32'(bubble), 32'd1);
    step(16'h02C0, 1'b0, 1'b0);
    check1("fl_flush", 32'(flush), 32'd1);
    check1("fl_stall", 32'(stall), 32'd0);
    check1("fl_fcnt", 32'(flush_cnt), 32'd1);
    step(16'h0000, 1'b1, 1'b0);
    check1("post_fl", 32'(flush), 32'd0);
    // bne not taken, late br_taken ignored
    step(16'h9000, 1'b0, 1'b0);
    step(16'h02C0, 1'b0, 1'b0);
    step(16'h02C0, 1'b1, 1'b0);
    check1("bne_noflush", 32'(flush), 32'd0);
    check1("bne_issue", 32'(issue), 32'd1);

    // reset inside the pending window of addi $2
    step(16'h4205, 1'b0, 1'b0);
    step(16'h0AC0, 1'b0, 1'b1);
    step(16'h0AC0, 1'b0, 1'b0);
    check1("rstpend_issue", 32'(issue), 32'd1);
    check1("rstpend_scnt", 32'(stall_cnt), 32'd0);

    // Unknown opcode and nop stream never stall
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 16'hFFC0 : 16'h0000, 1'b0, 1'b0);
      check1("nop_stall", 32'(stall), 32'd0);
    end

    // Drive both counters into saturation
    for (int i = 0; i < CMAX + 5; i++) begin
      step(16'h410F, 1'b0, 1'b0);
      step(16'h6900, 1'b0, 1'b0);
      step(16'h6900, 1'b0, 1'b0);
    end
    check1("scnt_sat", 32'(stall_cnt), 32'(CMAX));
    for (int i = 0; i < CMAX + 5; i++) begin
      step(16'h8000, 1'b0, 1'b0);
      step(16'h02C0, 1'b1, 1'b0);
      step(16'h02C0, 1'b0, 1'b0);
    end
    check1("fcnt_sat", 32'(flush_cnt), 32'(CMAX));

    // Random instruction stream following the modelled IF/ID register
    ifid_m = rand_ir();
    for (int i = 0; i < 4000; i++) begin
      step(ifid_m, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
